// File: rtl/pmsg_frame_gatherer_if.sv
// Beat-in / frame-out handshake bundle for pmsg_frame_gatherer.
interface pmsg_frame_gatherer_if #(
  parameter int UNIT_NUM   = 6,
  parameter int UNIT_WIDTH = 4,
  parameter int IN_UNITS   = 2,
  parameter int CNT_W      = 2
);
  logic [IN_UNITS*UNIT_WIDTH-1:0] in_data_i;
  logic [IN_UNITS-1:0]            in_mask_i;
  logic                           in_valid_i;
  logic                           in_last_i;
  logic                           in_ready_o;
  logic [UNIT_NUM*UNIT_WIDTH-1:0] out_data_o;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [CNT_W-1:0]               out_beats_o;

  modport master (
    output in_data_i, in_mask_i, in_valid_i, in_last_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, out_beats_o
  );

  modport slave (
    input  in_data_i, in_mask_i, in_valid_i, in_last_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, out_beats_o
  );
endinterface

// File: rtl/pmsg_frame_gatherer.sv
// Ping-pong frame gatherer: packs IN_UNITS-wide beats into UNIT_NUM-unit frames.
// Optional synchronous flush port enabled by PMSG_GATHER_FLUSH_EN.

// One unit slot, held in both banks; a bank reads as zero unless selected for output.
module pmsg_gather_unit #(
  parameter int W = 4
) (
  input  logic         sys_clk,
  input  logic         rstn,
  input  logic         i_flush,
  input  logic [1:0]   i_we,
  input  logic [1:0]   i_clr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd_sel,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rdata
);
  logic [1:0][W-1:0] r_bank;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_bank <= '0;
    end else if (i_flush) begin
      r_bank <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (i_clr[b])     r_bank[b] <= '0;
        else if (i_we[b]) r_bank[b] <= i_wdata;
      end
    end
  end

  assign o_rdata = i_rd_en ? r_bank[i_rd_sel] : '0;
endmodule

module pmsg_frame_gatherer #(
  parameter int UNIT_NUM   = 6,
  parameter int UNIT_WIDTH = 4,
  parameter int IN_UNITS   = 2,
  parameter int CNT_W      = 2
) (
  input  logic sys_clk,
  input  logic rstn,
`ifdef PMSG_GATHER_FLUSH_EN
  input  logic flush_i,
`endif
  pmsg_frame_gatherer_if.slave bus
);
  localparam int BEAT_NUM = UNIT_NUM / IN_UNITS;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEAT_NUM - 1);

  logic [1:0]            r_full;
  logic                  r_wr_sel;
  logic                  r_rd_sel;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [1:0][CNT_W-1:0] r_beats;

  logic [1:0]            w_full_nxt;
  logic                  w_wr_sel_nxt;
  logic                  w_rd_sel_nxt;
  logic [CNT_W-1:0]      w_beat_cnt_nxt;
  logic [1:0][CNT_W-1:0] w_beats_nxt;

  logic w_flush;
  logic w_in_ready;
  logic w_acc;
  logic w_done;
  logic w_out_valid;
  logic w_drain;
  logic [1:0] w_bank_clr;
  logic [UNIT_NUM-1:0][UNIT_WIDTH-1:0] w_frame;

`ifdef PMSG_GATHER_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  // Ready depends only on registered state, never on out_ready_i.
  assign w_in_ready  = ~r_full[r_wr_sel];
  assign w_acc       = bus.in_valid_i & w_in_ready;
  assign w_done      = w_acc & ((r_beat_cnt == LAST_BEAT) | bus.in_last_i);
  assign w_out_valid = r_full[r_rd_sel];
  assign w_drain     = w_out_valid & bus.out_ready_i;
  assign w_bank_clr  = {2{w_drain}} & {r_rd_sel, ~r_rd_sel};

  always_comb begin
    w_full_nxt     = r_full;
    w_wr_sel_nxt   = r_wr_sel;
    w_rd_sel_nxt   = r_rd_sel;
    w_beat_cnt_nxt = r_beat_cnt;
    w_beats_nxt    = r_beats;
    // A draining bank is always full, so it can never be the one being written.
    if (w_drain) begin
      w_full_nxt[r_rd_sel]  = 1'b0;
      w_beats_nxt[r_rd_sel] = '0;
      w_rd_sel_nxt          = ~r_rd_sel;
    end
    if (w_acc) begin
      if (w_done) begin
        w_full_nxt[r_wr_sel]  = 1'b1;
        w_beats_nxt[r_wr_sel] = r_beat_cnt + 1'b1;
        w_beat_cnt_nxt        = '0;
        w_wr_sel_nxt          = ~r_wr_sel;
      end else begin
        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
      end
    end
    if (w_flush) begin
      w_full_nxt     = '0;
      w_wr_sel_nxt   = 1'b0;
      w_rd_sel_nxt   = 1'b0;
      w_beat_cnt_nxt = '0;
      w_beats_nxt    = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_full     <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_beat_cnt <= '0;
      r_beats    <= '0;
    end else begin
      r_full     <= w_full_nxt;
      r_wr_sel   <= w_wr_sel_nxt;
      r_rd_sel   <= w_rd_sel_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_beats    <= w_beats_nxt;
    end
  end

  for (genvar i = 0; i < UNIT_NUM; i++) begin : g_unit
    localparam int K = i / IN_UNITS;
    localparam int J = i % IN_UNITS;
    logic [1:0]            w_we;
    logic [UNIT_WIDTH-1:0] w_lane;

    assign w_we   = {2{w_acc && (r_beat_cnt == CNT_W'(K))}} & {r_wr_sel, ~r_wr_sel};
    assign w_lane = bus.in_mask_i[J] ? bus.in_data_i[J*UNIT_WIDTH +: UNIT_WIDTH] : '0;

    pmsg_gather_unit #(.W(UNIT_WIDTH)) u_unit (
      .sys_clk  (sys_clk),
      .rstn     (rstn),
      .i_flush  (w_flush),
      .i_we     (w_we),
      .i_clr    (w_bank_clr),
      .i_wdata  (w_lane),
      .i_rd_sel (r_rd_sel),
      .i_rd_en  (w_out_valid),
      .o_rdata  (w_frame[i])
    );
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.out_data_o  = w_frame;
  assign bus.out_beats_o = w_out_valid ? r_beats[r_rd_sel] : '0;
endmodule

// File: doc/pmsg_frame_gatherer.md
Name: pmsg_frame_gatherer

Overview:
- Parametrised successor to the per-unit latch bus combiner in the partial message-passing path.
- Gathers a frame of UNIT_NUM message units, IN_UNITS units per beat over several beats, under a valid/ready handshake.
- Ping-pong double buffer: one frame drains downstream while the next fills, giving back-to-back throughput.
- Supports per-lane load masks and early frame close.

Parameters:
- UNIT_NUM, 6, units per output frame; must be an integer multiple of IN_UNITS.
- UNIT_WIDTH, 4, bits per message unit.
- IN_UNITS, 2, units accepted per input beat. Derived localparam BEAT_NUM = UNIT_NUM/IN_UNITS.
- CNT_W, 2, width of beat counter; must satisfy 2^CNT_W > BEAT_NUM.

Ports:
- sys_clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_data_i  input  IN_UNITS*UNIT_WIDTH  beat payload; lane j = bits [(j+1)*UNIT_WIDTH-1 : j*UNIT_WIDTH].
- in_mask_i  input  IN_UNITS  per-lane load enable; a lane with mask 0 is stored as zero.
- in_valid_i  input  1  beat valid.
- in_last_i  input  1  closes the frame on this beat.
- in_ready_o  output  1  beat accept.
- out_data_o  output  UNIT_NUM*UNIT_WIDTH  gathered frame; unit i at bits [(i+1)*UNIT_WIDTH-1 : i*UNIT_WIDTH].
- out_valid_o  output  1  frame valid.
- out_ready_i  input  1  frame accept.
- out_beats_o  output  CNT_W  number of beats received for the presented frame (1..BEAT_NUM).

Behaviour:
- Reset (async, rstn=0): both banks cleared to 0, full[1:0]=0, wr_sel=0, rd_sel=0, beat_cnt=0.
  - Resulting outputs: in_ready_o=1, out_valid_o=0, out_data_o=0, out_beats_o=0.
  - A reset mid-frame discards partial and pending frames; no output for them.
- Beat accept: in_valid_i & in_ready_o. Accepted beat k (= beat_cnt) writes lane j into unit k*IN_UNITS+j of bank wr_sel.
  - Masked-off lanes write 0.
  - Units never written in a frame are 0, because a bank is zeroed when it is freed.
- Frame completion: the accepted beat has beat_cnt==BEAT_NUM-1, or has in_last_i=1.
  - On completion, full[wr_sel] is set, the bank's beat count is stored as beat_cnt+1, beat_cnt returns to 0 and wr_sel toggles.
  - in_last_i on the final beat behaves identically to natural completion.
  - in_last_i on beat 0 gives a one-beat frame.
  - in_last_i without in_valid_i is ignored.
- in_ready_o = ~full[wr_sel], registered state only; there is no combinational path from out_ready_i.
  - Held beats (valid & ~ready) must be held stable by upstream.
- Output side:
  - out_valid_o = full[rd_sel].
  - out_data_o and out_beats_o show bank rd_sel.
  - Data and beat count are 0 whenever out_valid_o=0.
  - On out_valid_o & out_ready_i: full[rd_sel] cleared, the bank is zeroed, rd_sel toggles.
  - Payload is held stable while out_valid_o=1 and out_ready_i=0.
- Latency: completing beat accepted at edge t gives out_valid_o=1 after edge t (visible in cycle t+1).
- Throughput: one beat per cycle sustained with out_ready_i=1, and no bubbles between frames.
- Both banks full: in_ready_o=0.
- Same-cycle completion and drain on different banks: both take effect. The freed bank is writable on the next cycle.
- Reads and writes never target the same bank while it is full; the design contains no bypass path.

Optional Feature:
- Macro PMSG_GATHER_FLUSH_EN adds input port flush_i (1 bit, synchronous, active-high).
- With the macro defined, flush_i=1 at an edge produces the reset state at that edge.
  - flush_i overrides any simultaneous accept or drain.
  - Frames in flight are dropped.
- Without the macro defined, the port is absent and the logic is unchanged.

Test Plan:
- Reset, then 3 beats 0x21, 0x43, 0x65 with mask 2'b11, out_ready_i=1 → one cycle after 3rd accept: out_data_o=0x654321, out_beats_o=3, out_valid_o high for 1 cycle.
- Beat 0x21 mask 11, then beat 0x43 mask 2'b01 with in_last_i=1 → out_data_o=0x000321, out_beats_o=2.
- out_ready_i=0, send 2 full frames (0x654321, 0xCBA987) → in_ready_o=0 after 6th accept.
  - out_data_o holds 0x654321.
  - Raise out_ready_i: 0x654321 then 0xCBA987 drain on consecutive cycles, and in_ready_o returns to 1.
- Continuous valid beats for 4 frames with out_ready_i=1 → in_ready_o never deasserts; 4 frames out in order.
- Assert rstn=0 asynchronously mid-cycle after 2nd beat → out_valid_o=0, in_ready_o=1 immediately; next 3 beats form a clean new frame.
- With PMSG_GATHER_FLUSH_EN: flush_i=1 while one bank is full and another is half-filled → next cycle out_valid_o=0, out_data_o=0, beat_cnt=0.
